// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared FSM state type and defaults for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hz_state_e;

    localparam int REG_ADDR_W_DEF = 5;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - flags an ID-stage instruction that reads the destination of a load in EX
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - stall/flush sequencer for the 5-stage core; HAZARD_PERF_CNT_EN adds perf counters
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int FLUSH_CYCLES = 1
`ifdef HAZARD_PERF_CNT_EN
    ,parameter int PERF_CNT_W  = 32
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_en,
    output logic [1:0]            state_o
`ifdef HAZARD_PERF_CNT_EN
    ,output logic [PERF_CNT_W-1:0] stall_cycles
    ,output logic [PERF_CNT_W-1:0] flush_cycles
`endif
);

    hz_state_e state, state_n;
    logic [1:0] flush_cnt, flush_cnt_n;
    logic       load_use, lu_eff, mem_stall, do_flush;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // the instruction in EX right after a load-use stall is the bubble, so its load_use is stale
    assign lu_eff    = load_use && (state != LOAD_STALL);
    assign mem_stall = mem_req && !mem_ready;
    assign do_flush  = (state == FLUSH) || ((state == MEM_WAIT) && mem_ready && (flush_cnt != 2'd0));
    assign state_o   = state;

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        state_n     = state;
        flush_cnt_n = flush_cnt;
        if ((state == MEM_WAIT) && !mem_ready) begin
            state_n = MEM_WAIT;
        end else if (mem_stall) begin
            state_n = MEM_WAIT;
        end else if (do_flush) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_n = flush_cnt - 2'd1;
            state_n     = (flush_cnt == 2'd1) ? RUN : FLUSH;
        end else if (ex_branch_taken) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_n = 2'(FLUSH_CYCLES - 1);
            state_n     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (lu_eff) begin
            exmem_en    = 1'b1;
            idex_flush  = 1'b1;
            state_n     = LOAD_STALL;
        end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            exmem_en    = 1'b1;
            state_n     = RUN;
        end
        if (reset) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            exmem_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_en && (stall_cycles != '1))
                stall_cycles <= stall_cycles + PERF_CNT_W'(1);
            if (ifid_flush && (flush_cycles != '1))
                flush_cycles <= flush_cycles + PERF_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit (FLUSH_CYCLES=2)
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_en;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks = 0;
    int failures = 0;

    // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en}
    localparam logic [4:0] C_RUN    = 5'b11001;
    localparam logic [4:0] C_FREEZE = 5'b00000;
    localparam logic [4:0] C_FLUSH  = 5'b11111;
    localparam logic [4:0] C_LDUSE  = 5'b00011;

    wire [4:0] ctl = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en};

    hazard_ctrl_unit #(.REG_ADDR_W(5), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .state_o         (state_o)
`ifdef HAZARD_PERF_CNT_EN
        ,.stall_cycles   (stall_cycles)
        ,.flush_cycles   (flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #2;
        check("rst_ctl", 32'(ctl), 32'(C_FREEZE));
        check("rst_state", 32'(state_o), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_ctl", 32'(ctl), 32'(C_RUN));
        check("post_rst_state", 32'(state_o), 32'd0);

        // load-use on rs1, inputs held for the stall cycle
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; #1;
        check("lu_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        check("lu_next_state", 32'(state_o), 32'd1);
        check("lu_masked_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        clear_inputs(); #1;
        check("lu_back_run", 32'(state_o), 32'd0);

        // x0 destination never stalls
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        check("x0_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        check("x0_state", 32'(state_o), 32'd0);

        // load-use through rs2
        ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; #1;
        check("lu_rs2_ctl", 32'(ctl), 32'(C_LDUSE));
        tick();
        clear_inputs(); #1;
        check("lu_rs2_state", 32'(state_o), 32'd1);
        tick();

        // two-cycle branch flush, counters from a fresh reset
        do_reset();
        ex_branch_taken = 1'b1; #1;
        check("br_ctl0", 32'(ctl), 32'(C_FLUSH));
        tick();
        ex_branch_taken = 1'b0; #1;
        check("br_state1", 32'(state_o), 32'd2);
        check("br_ctl1", 32'(ctl), 32'(C_FLUSH));
        tick();
        check("br_state2", 32'(state_o), 32'd0);
        check("br_ctl2", 32'(ctl), 32'(C_RUN));
`ifdef HAZARD_PERF_CNT_EN
        check("br_flush_cnt", flush_cycles, 32'd2);
        check("br_stall_cnt", stall_cycles, 32'd0);
`endif

        // three-cycle memory wait
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0; #1;
        check("mw_ctl0", 32'(ctl), 32'(C_FREEZE));
        tick();
        check("mw_state1", 32'(state_o), 32'd3);
        check("mw_ctl1", 32'(ctl), 32'(C_FREEZE));
        ex_branch_taken = 1'b1; #1;
        check("mw_br_ignored", 32'(ctl), 32'(C_FREEZE));
        tick();
        ex_branch_taken = 1'b0; #1;
        check("mw_ctl2", 32'(ctl), 32'(C_FREEZE));
        tick();
        mem_ready = 1'b1; #1;
        check("mw_ready_ctl", 32'(ctl), 32'(C_RUN));
        tick();
        clear_inputs(); #1;
        check("mw_done_state", 32'(state_o), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("mw_stall_cnt", stall_cycles, 32'd3);
`endif

        // memory wait interrupting a flush resumes the remaining flush cycle
        ex_branch_taken = 1'b1; #1;
        tick();
        ex_branch_taken = 1'b0; mem_req = 1'b1; #1;
        check("fw_freeze", 32'(ctl), 32'(C_FREEZE));
        tick();
        check("fw_state", 32'(state_o), 32'd3);
        mem_ready = 1'b1; #1;
        check("fw_resume_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        clear_inputs(); #1;
        check("fw_back_run", 32'(state_o), 32'd0);

        // branch + load-use + ready memory in one cycle: flush wins
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        mem_req = 1'b1; mem_ready = 1'b1; #1;
        check("combo_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        clear_inputs(); #1;
        check("combo_state", 32'(state_o), 32'd2);

        // reset mid-FLUSH
        reset = 1'b1; #1;
        check("rst_flush_state", 32'(state_o), 32'd0);
        check("rst_flush_ctl", 32'(ctl), 32'(C_FREEZE));
        tick();
        reset = 1'b0; #1;

        // reset mid-MEM_WAIT
        mem_req = 1'b1; tick();
        check("pre_rst_mw", 32'(state_o), 32'd3);
        reset = 1'b1; #1;
        check("rst_mw_state", 32'(state_o), 32'd0);
        check("rst_mw_ctl", 32'(ctl), 32'(C_FREEZE));
        clear_inputs();
        tick();
        reset = 1'b0; #1;
        check("rel_ctl", 32'(ctl), 32'(C_RUN));
`ifdef HAZARD_PERF_CNT_EN
        check("rel_stall_cnt", stall_cycles, 32'd0);
        check("rel_flush_cnt", flush_cycles, 32'd0);
`endif
        tick();
        check("rel_state", 32'(state_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
